// File: rtl/pkt_flow_stat_rx.sv
// Per-flow receive statistics: packet, L2 byte and L1 byte counters per flow,
// plus global framing/flow error counters, with a registered commit stage.
module pkt_flow_stat_rx #(
    parameter int D_WIDTH     = 64,
    parameter int EMPTY_WIDTH = 3,
    parameter int FLOW_CNT    = 16,
    localparam int FLOW_W     = $clog2(FLOW_CNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [D_WIDTH-1:0]     data,
    input  logic                   sop,
    input  logic                   eop,
    input  logic [EMPTY_WIDTH-1:0] empty,
    input  logic                   val,
    input  logic [FLOW_W-1:0]      flow_num,
    input  logic                   clr_stb,
    input  logic                   rd_req,
    input  logic [FLOW_W-1:0]      rd_flow,
    output logic                   rd_val,
    output logic [31:0]            rd_pkt_cnt,
    output logic [47:0]            rd_byte_cnt,
    output logic [47:0]            rd_l1_byte_cnt,
    output logic [15:0]            err_no_sop_cnt,
    output logic [15:0]            err_no_eop_cnt,
    output logic [15:0]            err_flow_cnt
);

    localparam int          BPW    = D_WIDTH / 8;
    localparam logic [15:0] BPW16  = 16'(BPW);
    localparam logic [47:0] L1_OVH = 48'd24;

    typedef enum logic {IDLE, IN_PKT} state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [47:0] b);
        logic [48:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[48] ? {48{1'b1}} : s[47:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    // Payload is never inspected.
    logic unused_data;
    assign unused_data = ^data;

    state_t              state_q, state_d;
    logic [FLOW_W-1:0]   pkt_flow_q, pkt_flow_d;
    logic [15:0]         cur_len_q, cur_len_d;

    logic                cm_vld_q, cm_vld_d;
    logic [FLOW_W-1:0]   cm_flow_q, cm_flow_d;
    logic [15:0]         cm_len_q, cm_len_d;

    logic [31:0]         pkt_cnt_q  [FLOW_CNT];
    logic [31:0]         pkt_cnt_d  [FLOW_CNT];
    logic [47:0]         byte_cnt_q [FLOW_CNT];
    logic [47:0]         byte_cnt_d [FLOW_CNT];
    logic [47:0]         l1_cnt_q   [FLOW_CNT];
    logic [47:0]         l1_cnt_d   [FLOW_CNT];

    logic [15:0]         err_no_sop_q, err_no_sop_d;
    logic [15:0]         err_no_eop_q, err_no_eop_d;
    logic [15:0]         err_flow_q, err_flow_d;

    logic                rd_val_q, rd_val_d;
    logic [31:0]         rd_pkt_q, rd_pkt_d;
    logic [47:0]         rd_byte_q, rd_byte_d;
    logic [47:0]         rd_l1_q, rd_l1_d;

    logic                inc_no_sop, inc_no_eop, inc_flow;
    logic [15:0]         eop_bytes;
    logic [15:0]         tail_len;

    assign eop_bytes = BPW16 - {{(16-EMPTY_WIDTH){1'b0}}, empty};
    assign tail_len  = sat_add16(cur_len_q, eop_bytes);

    // Framing FSM; a completed packet is handed to the commit stage.
    always_comb begin
        state_d    = state_q;
        pkt_flow_d = pkt_flow_q;
        cur_len_d  = cur_len_q;
        cm_vld_d   = 1'b0;
        cm_flow_d  = cm_flow_q;
        cm_len_d   = cm_len_q;
        inc_no_sop = 1'b0;
        inc_no_eop = 1'b0;
        inc_flow   = 1'b0;
        if (val) begin
            if (sop) begin
                // A sop while a packet is open abandons that packet.
                inc_no_eop = (state_q == IN_PKT);
                if (eop) begin
                    cm_vld_d  = 1'b1;
                    cm_flow_d = flow_num;
                    cm_len_d  = eop_bytes;
                    cur_len_d = eop_bytes;
                    state_d   = IDLE;
                end else begin
                    pkt_flow_d = flow_num;
                    cur_len_d  = BPW16;
                    state_d    = IN_PKT;
                end
            end else if (state_q == IDLE) begin
                inc_no_sop = 1'b1;
            end else begin
                inc_flow = (flow_num != pkt_flow_q);
                if (eop) begin
                    cm_vld_d  = 1'b1;
                    cm_flow_d = pkt_flow_q;
                    cm_len_d  = tail_len;
                    cur_len_d = tail_len;
                    state_d   = IDLE;
                end else begin
                    cur_len_d = sat_add16(cur_len_q, BPW16);
                end
            end
        end
    end

    // Counter update; clear overrides any commit or error increment this cycle.
    always_comb begin
        pkt_cnt_d    = pkt_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        l1_cnt_d     = l1_cnt_q;
        err_no_sop_d = err_no_sop_q;
        err_no_eop_d = err_no_eop_q;
        err_flow_d   = err_flow_q;
        if (clr_stb) begin
            for (int i = 0; i < FLOW_CNT; i++) begin
                pkt_cnt_d[i]  = '0;
                byte_cnt_d[i] = '0;
                l1_cnt_d[i]   = '0;
            end
            err_no_sop_d = '0;
            err_no_eop_d = '0;
            err_flow_d   = '0;
        end else begin
            if (cm_vld_q) begin
                pkt_cnt_d[cm_flow_q]  = sat_inc32(pkt_cnt_q[cm_flow_q]);
                byte_cnt_d[cm_flow_q] = sat_add48(byte_cnt_q[cm_flow_q], 48'(cm_len_q));
                l1_cnt_d[cm_flow_q]   = sat_add48(l1_cnt_q[cm_flow_q], 48'(cm_len_q) + L1_OVH);
            end
            if (inc_no_sop) err_no_sop_d = sat_inc16(err_no_sop_q);
            if (inc_no_eop) err_no_eop_d = sat_inc16(err_no_eop_q);
            if (inc_flow)   err_flow_d   = sat_inc16(err_flow_q);
        end
    end

    // Reads sample the pre-update array, so a same-cycle commit is seen next time.
    always_comb begin
        rd_val_d  = rd_req;
        rd_pkt_d  = rd_pkt_q;
        rd_byte_d = rd_byte_q;
        rd_l1_d   = rd_l1_q;
        if (rd_req) begin
            rd_pkt_d  = pkt_cnt_q[rd_flow];
            rd_byte_d = byte_cnt_q[rd_flow];
            rd_l1_d   = l1_cnt_q[rd_flow];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pkt_flow_q   <= '0;
            cur_len_q    <= '0;
            cm_vld_q     <= 1'b0;
            cm_flow_q    <= '0;
            cm_len_q     <= '0;
            for (int i = 0; i < FLOW_CNT; i++) begin
                pkt_cnt_q[i]  <= '0;
                byte_cnt_q[i] <= '0;
                l1_cnt_q[i]   <= '0;
            end
            err_no_sop_q <= '0;
            err_no_eop_q <= '0;
            err_flow_q   <= '0;
            rd_val_q     <= 1'b0;
            rd_pkt_q     <= '0;
            rd_byte_q    <= '0;
            rd_l1_q      <= '0;
        end else begin
            state_q      <= state_d;
            pkt_flow_q   <= pkt_flow_d;
            cur_len_q    <= cur_len_d;
            cm_vld_q     <= cm_vld_d;
            cm_flow_q    <= cm_flow_d;
            cm_len_q     <= cm_len_d;
            pkt_cnt_q    <= pkt_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            l1_cnt_q     <= l1_cnt_d;
            err_no_sop_q <= err_no_sop_d;
            err_no_eop_q <= err_no_eop_d;
            err_flow_q   <= err_flow_d;
            rd_val_q     <= rd_val_d;
            rd_pkt_q     <= rd_pkt_d;
            rd_byte_q    <= rd_byte_d;
            rd_l1_q      <= rd_l1_d;
        end
    end

    assign rd_val         = rd_val_q;
    assign rd_pkt_cnt     = rd_pkt_q;
    assign rd_byte_cnt    = rd_byte_q;
    assign rd_l1_byte_cnt = rd_l1_q;
    assign err_no_sop_cnt = err_no_sop_q;
    assign err_no_eop_cnt = err_no_eop_q;
    assign err_flow_cnt   = err_flow_q;

endmodule
